// File: rtl/peripheral_msi_slave_port_ahb3.sv
// Slave-side port of the MSI AHB3 interconnect: priority/round-robin arbiter plus address/data muxes.
// Latency: grant registered one cycle after a committed request; address/data muxes are combinational.
// Backpressure: slv_HREADY=0 freezes grant, round-robin pointer and data-phase owner; only that owner sees wait/resp.
module peripheral_msi_slave_port_ahb3 #(
    parameter int PLEN    = 64,
    parameter int XLEN    = 64,
    parameter int MASTERS = 5
) (
    input  logic                        HCLK,
    input  logic                        HRESET,

    input  logic [MASTERS-1:0][2:0]     mstpriority,
    input  logic [MASTERS-1:0]          mstHSEL,
    input  logic [MASTERS-1:0][PLEN-1:0] mstHADDR,
    input  logic [MASTERS-1:0][XLEN-1:0] mstHWDATA,
    output logic [XLEN-1:0]             mstHRDATA,
    input  logic [MASTERS-1:0]          mstHWRITE,
    input  logic [MASTERS-1:0][2:0]     mstHSIZE,
    input  logic [MASTERS-1:0][2:0]     mstHBURST,
    input  logic [MASTERS-1:0][3:0]     mstHPROT,
    input  logic [MASTERS-1:0][1:0]     mstHTRANS,
    input  logic [MASTERS-1:0]          mstHMASTLOCK,
    input  logic [MASTERS-1:0]          mstHREADY,
    output logic [MASTERS-1:0]          mstHREADYOUT,
    output logic [MASTERS-1:0]          mstHRESP,

    input  logic [MASTERS-1:0]          can_switch,
    output logic [MASTERS-1:0]          master_granted,

    output logic                        slv_HSEL,
    output logic [PLEN-1:0]             slv_HADDR,
    output logic [XLEN-1:0]             slv_HWDATA,
    input  logic [XLEN-1:0]             slv_HRDATA,
    output logic                        slv_HWRITE,
    output logic [2:0]                  slv_HSIZE,
    output logic [2:0]                  slv_HBURST,
    output logic [3:0]                  slv_HPROT,
    output logic [1:0]                  slv_HTRANS,
    output logic                        slv_HMASTLOCK,
    output logic                        slv_HREADYOUT,
    input  logic                        slv_HREADY,
    input  logic                        slv_HRESP
);

    localparam int MASTER_BITS = $clog2(MASTERS);
    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    logic [MASTER_BITS-1:0] gnt_idx_q, gnt_idx_d;
    logic [MASTER_BITS-1:0] rr_ptr_q,  rr_ptr_d;
    logic [MASTER_BITS-1:0] dph_idx_q, dph_idx_d;
    logic                   dph_valid_q, dph_valid_d;

    logic                   any_req;
    logic [2:0]             max_prio;
    logic [MASTER_BITS-1:0] winner;
    logic                   found;
    logic [MASTER_BITS-1:0] cand;
    int                     j;
    logic                   switch_ok;

    // Arbitration: highest priority among requesters, ties resolved by first requester after rr_ptr.
    always_comb begin
        any_req  = 1'b0;
        max_prio = 3'd0;
        winner   = gnt_idx_q;
        found    = 1'b0;
        cand     = '0;
        j        = 0;
        for (int m = 0; m < MASTERS; m++) begin
            if (mstHSEL[m]) begin
                any_req = 1'b1;
                if (mstpriority[m] > max_prio) begin
                    max_prio = mstpriority[m];
                end
            end
        end
        for (int k = 1; k <= MASTERS; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= MASTERS) begin
                j = j - MASTERS;
            end
            cand = MASTER_BITS'(j);
            if (!found && mstHSEL[cand] && (mstpriority[cand] == max_prio)) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // The current owner may hand over only when idle or when its port allows release.
    assign switch_ok = ~mstHSEL[gnt_idx_q] | can_switch[gnt_idx_q];

    // Next-state: everything advances only on a ready slave; an empty request set parks the grant.
    always_comb begin
        gnt_idx_d   = gnt_idx_q;
        rr_ptr_d    = rr_ptr_q;
        dph_idx_d   = dph_idx_q;
        dph_valid_d = dph_valid_q;
        if (slv_HREADY) begin
            dph_valid_d = slv_HSEL & slv_HTRANS[1];
            dph_idx_d   = gnt_idx_q;
            if (switch_ok && any_req) begin
                gnt_idx_d = winner;
                rr_ptr_d  = winner;
            end
        end
    end

    // State registers with synchronous reset; a reset mid-transfer drops the data phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            gnt_idx_q   <= '0;
            rr_ptr_q    <= MASTER_BITS'(MASTERS - 1);
            dph_idx_q   <= '0;
            dph_valid_q <= 1'b0;
        end else begin
            gnt_idx_q   <= gnt_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            dph_idx_q   <= dph_idx_d;
            dph_valid_q <= dph_valid_d;
        end
    end

    // One-hot grant and per-master response routing; only the data-phase owner sees waits/errors.
    always_comb begin
        master_granted = '0;
        master_granted[gnt_idx_q] = 1'b1;
        for (int m = 0; m < MASTERS; m++) begin
            if (dph_valid_q && (MASTER_BITS'(m) == dph_idx_q)) begin
                mstHREADYOUT[m] = slv_HREADY;
                mstHRESP[m]     = slv_HRESP;
            end else begin
                mstHREADYOUT[m] = 1'b1;
                mstHRESP[m]     = 1'b0;
            end
        end
    end

    assign slv_HSEL      = mstHSEL[gnt_idx_q];
    assign slv_HTRANS    = mstHSEL[gnt_idx_q] ? mstHTRANS[gnt_idx_q] : HTRANS_IDLE;
    assign slv_HADDR     = mstHADDR[gnt_idx_q];
    assign slv_HWRITE    = mstHWRITE[gnt_idx_q];
    assign slv_HSIZE     = mstHSIZE[gnt_idx_q];
    assign slv_HBURST    = mstHBURST[gnt_idx_q];
    assign slv_HPROT     = mstHPROT[gnt_idx_q];
    assign slv_HMASTLOCK = mstHMASTLOCK[gnt_idx_q];
    assign slv_HREADYOUT = mstHREADY[gnt_idx_q];

    assign slv_HWDATA    = mstHWDATA[dph_idx_q];
    assign mstHRDATA     = slv_HRDATA;

endmodule
